// File: rtl/rtan_sweep_sequencer.sv
// rtan_sweep_sequencer: latches r for the tan stage, waits for it to settle, then streams six captured magnitudes
module rtan_sweep_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int IDX_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [8:0]       r_in,
  output logic             busy,
  output logic [8:0]       r_to_calc,
  input  logic [7:0]       abs7rtan_00,
  input  logic [7:0]       abs7rtan_15,
  input  logic [7:0]       abs7rtan_30,
  input  logic [7:0]       abs7rtan_45,
  input  logic [7:0]       abs7rtan_60,
  input  logic [7:0]       abs7rtan_75,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [7:0]       out_mag,
  output logic             out_neg,
  output logic             out_last,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, EMIT, DONE} state_t;
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [8:0]       r_q, r_d;
  logic [7:0]       slot_q [6];
  logic [7:0]       slot_d [6];
  logic             valid_q, valid_d, neg_q, neg_d, last_q, last_d;
  logic [IDX_W-1:0] idx_q, idx_d, nidx;
  logic [7:0]       mag_q, mag_d, nmag;
  assign nidx = idx_q + IDX_W'(1);
  assign nmag = nidx == IDX_W'(1) ? slot_q[1] :
                nidx == IDX_W'(2) ? slot_q[2] :
                nidx == IDX_W'(3) ? slot_q[3] :
                nidx == IDX_W'(4) ? slot_q[4] :
                nidx == IDX_W'(5) ? slot_q[5] : slot_q[0];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    mag_d   = mag_q;
    neg_d   = neg_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (start) begin
        r_d     = r_in;
        cnt_d   = '0;
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d   = cnt_q + 4'd1;
        state_d = cnt_q == 4'(SETTLE_CYCLES - 1) ? CAPTURE : SETTLE;
      end
      CAPTURE: begin
        slot_d  = '{abs7rtan_00, abs7rtan_15, abs7rtan_30, abs7rtan_45, abs7rtan_60, abs7rtan_75};
        idx_d   = '0;
        mag_d   = abs7rtan_00;
        neg_d   = r_q[8];
        valid_d = 1'b1;
        last_d  = 1'b0;
        state_d = EMIT;
      end
      EMIT: if (out_ready) begin
        if (last_q) begin
          valid_d = 1'b0;
          state_d = DONE;
        end else begin
          idx_d  = nidx;
          mag_d  = nmag;
          last_d = nidx == IDX_W'(5);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      slot_q  <= '{default: '0};
      valid_q <= 1'b0;
      idx_q   <= '0;
      mag_q   <= '0;
      neg_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      slot_q  <= slot_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      mag_q   <= mag_d;
      neg_q   <= neg_d;
      last_q  <= last_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign r_to_calc = r_q;
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_mag   = mag_q;
  assign out_neg   = neg_q;
  assign out_last  = last_q;
endmodule

// File: tb/tb_rtan_sweep_sequencer.sv
// tb_rtan_sweep_sequencer: directed scenarios against the default and a SETTLE_CYCLES=4 instance
module tb_rtan_sweep_sequencer;
  logic clock = 1'b0, reset_n = 1'b0;
  logic start = 1'b0, out_ready = 1'b0, start4 = 1'b0, out_ready4 = 1'b0;
  logic [8:0] r_in = '0, r_in4 = '0, r_to_calc, r_to_calc4;
  logic [7:0] tan [6];
  logic busy, out_valid, out_neg, out_last, done;
  logic busy4, out_valid4, out_neg4, out_last4, done4;
  logic [2:0] out_idx, out_idx4;
  logic [7:0] out_mag, out_mag4;
  logic [7:0] exp_mag [6] = '{8'd0, 8'd27, 8'd58, 8'd100, 8'd173, 8'd117};
  int vectors = 0, errors = 0;
  always #5 clock = ~clock;
  rtan_sweep_sequencer dut (
    .clock(clock), .reset_n(reset_n), .start(start), .r_in(r_in), .busy(busy), .r_to_calc(r_to_calc),
    .abs7rtan_00(tan[0]), .abs7rtan_15(tan[1]), .abs7rtan_30(tan[2]),
    .abs7rtan_45(tan[3]), .abs7rtan_60(tan[4]), .abs7rtan_75(tan[5]),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_mag(out_mag),
    .out_neg(out_neg), .out_last(out_last), .done(done));
  rtan_sweep_sequencer #(.SETTLE_CYCLES(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .start(start4), .r_in(r_in4), .busy(busy4), .r_to_calc(r_to_calc4),
    .abs7rtan_00(tan[0]), .abs7rtan_15(tan[1]), .abs7rtan_30(tan[2]),
    .abs7rtan_45(tan[3]), .abs7rtan_60(tan[4]), .abs7rtan_75(tan[5]),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_idx(out_idx4), .out_mag(out_mag4),
    .out_neg(out_neg4), .out_last(out_last4), .done(done4));
  task automatic set_stub(input logic [7:0] v);
    for (int i = 0; i < 6; i++) tan[i] = v;
  endtask
  task automatic stub_default();
    for (int i = 0; i < 6; i++) tan[i] = exp_mag[i];
  endtask
  task automatic start_sweep(input logic [8:0] r);
    r_in = r;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
  endtask
  task automatic test_reset();
    #1;
    vectors++;
    if ({busy, r_to_calc, out_valid, out_idx, out_mag, out_neg, out_last, done} !== 24'd0) begin
      errors++;
      $display("FAIL reset_state got %h want 0", {busy, r_to_calc, out_valid, out_idx, out_mag, out_neg, out_last, done});
    end
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask
  task automatic test_basic();
    stub_default();
    out_ready = 1'b1;
    r_in = 9'd100;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    vectors++;
    if (r_to_calc !== 9'd100 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latch r=%0d busy=%b valid=%b want r=100 busy=1 valid=0", r_to_calc, busy, out_valid);
    end
    @(negedge clock);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid got %b want 0", out_valid);
    end
    @(negedge clock);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_mag !== exp_mag[i] || out_neg !== 1'b0 ||
          out_last !== (i == 5) || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_beat%0d got v=%b idx=%0d mag=%0d neg=%b last=%b done=%b want v=1 idx=%0d mag=%0d neg=0 last=%b done=0",
                 i, out_valid, out_idx, out_mag, out_neg, out_last, done, i, exp_mag[i], i == 5);
      end
      @(negedge clock);
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b valid=%b want 1 1 0", done, busy, out_valid);
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask
  task automatic test_negative();
    out_ready = 1'b1;
    start_sweep(9'h19C);
    vectors++;
    if (r_to_calc !== 9'h19C) begin
      errors++;
      $display("FAIL neg_latch got %h want 19c", r_to_calc);
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_mag !== exp_mag[i] || out_neg !== 1'b1) begin
        errors++;
        $display("FAIL neg_beat%0d got v=%b idx=%0d mag=%0d neg=%b want 1 %0d %0d 1",
                 i, out_valid, out_idx, out_mag, out_neg, i, exp_mag[i]);
      end
      @(negedge clock);
    end
    @(negedge clock);
  endtask
  task automatic test_backpressure();
    out_ready = 1'b1;
    start_sweep(9'd100);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_mag !== exp_mag[i]) begin
        errors++;
        $display("FAIL bp_beat%0d got v=%b idx=%0d mag=%0d want 1 %0d %0d", i, out_valid, out_idx, out_mag, i, exp_mag[i]);
      end
      if (i == 2) begin
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
          @(negedge clock);
          vectors++;
          if (out_valid !== 1'b1 || out_idx !== 3'd2 || out_mag !== 8'd58 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d got v=%b idx=%0d mag=%0d last=%b want 1 2 58 0", k, out_valid, out_idx, out_mag, out_last);
          end
        end
        out_ready = 1'b1;
      end
      @(negedge clock);
    end
    vectors++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done got %b want 1", done);
    end
    @(negedge clock);
  endtask
  task automatic test_alternating();
    int beats = 0;
    out_ready = 1'b1;
    start_sweep(9'd100);
    for (int c = 0; c < 11; c++) begin
      out_ready = (c % 2) == 0;
      if (out_valid && out_ready) begin
        vectors++;
        if (beats > 5 || out_idx !== 3'(beats) || out_mag !== exp_mag[beats % 6]) begin
          errors++;
          $display("FAIL alt_beat%0d got idx=%0d mag=%0d want idx=%0d", beats, out_idx, out_mag, beats);
        end
        beats++;
      end
      @(negedge clock);
    end
    out_ready = 1'b1;
    vectors++;
    if (beats !== 6 || done !== 1'b1) begin
      errors++;
      $display("FAIL alt_count got beats=%0d done=%b want 6 1", beats, done);
    end
    @(negedge clock);
  endtask
  task automatic test_isolation();
    out_ready = 1'b1;
    start_sweep(9'd100);
    set_stub(8'hFF);
    for (int i = 0; i < 6; i++) begin
      start = i == 1;
      r_in = 9'd5;
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_mag !== exp_mag[i] || r_to_calc !== 9'd100) begin
        errors++;
        $display("FAIL iso_beat%0d got v=%b idx=%0d mag=%0d r=%0d want 1 %0d %0d 100",
                 i, out_valid, out_idx, out_mag, r_to_calc, i, exp_mag[i]);
      end
      @(negedge clock);
    end
    start = 1'b0;
    @(negedge clock);
    vectors++;
    if (busy !== 1'b0 || r_to_calc !== 9'd100) begin
      errors++;
      $display("FAIL iso_idle got busy=%b r=%0d want 0 100", busy, r_to_calc);
    end
    stub_default();
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b1;
    start_sweep(9'd100);
    repeat (3) @(negedge clock);
    vectors++;
    if (out_idx !== 3'd3) begin
      errors++;
      $display("FAIL rst_pre got idx=%0d want 3", out_idx);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, r_to_calc, out_valid, out_idx, out_mag, out_neg, out_last, done} !== 24'd0) begin
      errors++;
      $display("FAIL rst_async got %h want 0", {busy, r_to_calc, out_valid, out_idx, out_mag, out_neg, out_last, done});
    end
    @(negedge clock);
    vectors++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold got done=%b valid=%b want 0 0", done, out_valid);
    end
    reset_n = 1'b1;
    @(negedge clock);
    start_sweep(9'd100);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid !== 1'b1 || out_idx !== 3'(i) || out_mag !== exp_mag[i]) begin
        errors++;
        $display("FAIL rst_resweep%0d got v=%b idx=%0d mag=%0d want 1 %0d %0d", i, out_valid, out_idx, out_mag, i, exp_mag[i]);
      end
      @(negedge clock);
    end
    vectors++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL rst_resweep_done got %b want 1", done);
    end
    @(negedge clock);
  endtask
  task automatic test_settle4_back_to_back();
    out_ready4 = 1'b1;
    r_in4 = 9'd0;
    start4 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clock);
      vectors++;
      if (out_valid4 !== (e == 6)) begin
        errors++;
        $display("FAIL s4_latency edge%0d got valid=%b want %b", e, out_valid4, e == 6);
      end
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid4 !== 1'b1 || out_idx4 !== 3'(i) || out_mag4 !== exp_mag[i] || out_neg4 !== 1'b0 || out_last4 !== (i == 5)) begin
        errors++;
        $display("FAIL s4_beat%0d got v=%b idx=%0d mag=%0d neg=%b last=%b", i, out_valid4, out_idx4, out_mag4, out_neg4, out_last4);
      end
      @(negedge clock);
    end
    r_in4 = 9'h100;
    vectors++;
    if (done4 !== 1'b1 || busy4 !== 1'b1) begin
      errors++;
      $display("FAIL s4_done got done=%b busy=%b want 1 1", done4, busy4);
    end
    @(negedge clock);
    vectors++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL s4_idle got busy=%b done=%b want 0 0", busy4, done4);
    end
    @(negedge clock);
    start4 = 1'b0;
    vectors++;
    if (busy4 !== 1'b1 || r_to_calc4 !== 9'h100 || out_valid4 !== 1'b0) begin
      errors++;
      $display("FAIL s4_restart got busy=%b r=%h valid=%b want 1 100 0", busy4, r_to_calc4, out_valid4);
    end
    for (int e = 2; e <= 6; e++) begin
      @(negedge clock);
      vectors++;
      if (out_valid4 !== (e == 6)) begin
        errors++;
        $display("FAIL s4_second_latency edge%0d got valid=%b want %b", e, out_valid4, e == 6);
      end
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (out_valid4 !== 1'b1 || out_idx4 !== 3'(i) || out_mag4 !== exp_mag[i] || out_neg4 !== 1'b1) begin
        errors++;
        $display("FAIL s4_second_beat%0d got v=%b idx=%0d mag=%0d neg=%b want neg=1", i, out_valid4, out_idx4, out_mag4, out_neg4);
      end
      @(negedge clock);
    end
    vectors++;
    if (done4 !== 1'b1) begin
      errors++;
      $display("FAIL s4_second_done got %b want 1", done4);
    end
    @(negedge clock);
  endtask
  initial begin
    stub_default();
    @(negedge clock);
    test_reset();
    test_basic();
    test_negative();
    test_backpressure();
    test_alternating();
    test_isolation();
    test_reset_mid();
    test_settle4_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/rtan_sweep_sequencer.md
Name: rtan_sweep_sequencer

Overview:
- Sits directly upstream of the combinational |r·tan(θ)| stage (0–75°, 15° steps, 8-bit outputs).
- On a start pulse, latches one signed range value and drives it into that stage.
- Waits a programmable settle time, then snapshots all six 8-bit magnitudes.
- Streams them out one per handshake, tagged with angle index and sign of r, for the downstream point-plotting logic.

Parameters:
SETTLE_CYCLES, 1, cycles r_to_calc is held stable before capture; legal range 1..15
IDX_W, 3, width of angle index output; fixed at 3 for six angles

Ports:
clock  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request; sampled only in IDLE
r_in  input  9  signed range value to convert
busy  output  1  high from the cycle after start is accepted through the DONE cycle
r_to_calc  output  9  registered signed r driven into the tan stage
abs7rtan_00  input  8  |r·tan0°| from tan stage
abs7rtan_15  input  8  |r·tan15°|
abs7rtan_30  input  8  |r·tan30°|
abs7rtan_45  input  8  |r·tan45°|
abs7rtan_60  input  8  |r·tan60°|
abs7rtan_75  input  8  |r·tan75°|
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat when high with out_valid
out_idx  output  3  angle index 0..5 (angle = 15·idx degrees)
out_mag  output  8  captured magnitude for out_idx
out_neg  output  1  sign bit of latched r (r_to_calc[8])
out_last  output  1  high with out_idx==5
done  output  1  one-cycle pulse after last beat accepted

Behaviour:
- Reset state: reset_n low forces, asynchronously, state=IDLE, r_to_calc=0, busy=0, out_valid=0, out_idx=0, out_mag=0, out_neg=0, out_last=0, done=0, settle counter=0, six capture registers=0.
- States: IDLE, SETTLE, CAPTURE, EMIT, DONE.
- IDLE, start=1: r_to_calc<=r_in, counter<=0, go to SETTLE. start=0: stay in IDLE.
- SETTLE: counter increments each cycle. When counter==SETTLE_CYCLES-1, go to CAPTURE. SETTLE lasts exactly SETTLE_CYCLES cycles.
- CAPTURE, one cycle:
  - Register all six abs7rtan inputs into capture slots 0..5.
  - out_idx<=0, out_mag<=slot-0 input, out_neg<=r_to_calc[8], out_valid<=1, out_last<=0.
  - Go to EMIT.
- Latency: first out_valid is high SETTLE_CYCLES+2 rising edges after the edge that samples start (3 edges at default).
- EMIT:
  - While out_valid && !out_ready, all out_* hold stable.
  - On out_valid && out_ready with idx<5: idx+1, out_mag=slot[idx+1], out_last=(idx+1==5). No bubble between beats; a continuous-ready sink sees 6 beats in 6 cycles.
  - On accept with idx==5: out_valid<=0, go to DONE.
- DONE, one cycle: done=1, busy=1. Next cycle: IDLE, busy=0.
- busy: 1 in SETTLE, CAPTURE, EMIT and DONE; 0 in IDLE. It rises one cycle after the start-sampling edge.
- start outside IDLE is ignored; no queuing. A start held high across DONE→IDLE is accepted in the first IDLE cycle.
- r_to_calc holds its value from latch until the next accepted start, including in IDLE.
- Width rules:
  - Magnitudes pass through unmodified; no saturation.
  - out_neg is the raw sign bit, so r=0 gives 0 and r=-256 gives 1.
  - No arithmetic is performed on captured data.
- Captured values are immune to tan-stage input changes after CAPTURE.
- Reset mid-operation (any state): immediate return to reset values. No done pulse; partial beats are abandoned.

Test Plan:
- Basic sweep: stub drives tan inputs 0,27,58,100,173,117; start with r_in=+100, out_ready=1.
  - r_to_calc=100 one edge after start.
  - out_valid rises 3 edges after start.
  - Beats (idx,mag) = (0,0),(1,27),(2,58),(3,100),(4,173),(5,117) on consecutive cycles, out_neg=0, out_last only on idx 5.
  - done pulses the cycle after beat 5; busy falls the next cycle.
- Negative r: r_in=-100 (9'h19C) with the same stub values → identical magnitudes, out_neg=1 on all six beats.
- Backpressure:
  - out_ready low for 4 cycles at idx 2 → idx=2, mag=58 held stable all 4 cycles; resumes with idx 3 when ready returns.
  - Alternating ready (1,0,1,0…) → 6 beats over 11 cycles, none lost or duplicated.
- Input isolation / start-ignore:
  - Change stub inputs to 0xFF after CAPTURE → beats still carry the captured values.
  - Pulse start with r_in=5 during EMIT → ignored; r_to_calc stays 100.
- Reset mid-EMIT: assert reset_n low at idx 3 → all outputs 0 asynchronously, no done. After release, a new start runs a full 6-beat sweep.
- Parameter: SETTLE_CYCLES=4 → first out_valid 6 edges after start. Back-to-back start held high → second sweep's SETTLE begins the cycle after busy falls.
